// File: rtl/mem_stream_port.sv
// Byte-stream front end for a 32-bit block RAM: LOAD writes an 8-bit valid/ready
// stream into the RAM lane by lane (little-endian), DUMP reads words back out as bytes.
module mem_stream_port #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_load,
   input  logic              start_dump,
   input  logic [ADDR_W:0]   len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0]        m_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_din,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [31:0]       mem_q
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DREQ, S_DWAIT, S_EMIT} state_t;

   localparam logic [ADDR_W:0]   LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LP_WA1   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [ADDR_W-1:0] r_wa;
   logic [1:0]        r_ln;
   logic [ADDR_W:0]   r_len;
   logic [31:0]       r_shift;
   logic              r_s_ready;
   logic              r_m_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [3:0]        r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [ADDR_W-1:0] r_raddr;
   logic [31:0]       r_din;

   logic w_last_word;
   logic w_len_zero;
   logic w_len_bad;

   // Compared at full len width so len = 2^ADDR_W completes at wa = depth-1 without wrapping.
   assign w_last_word = ({1'b0, r_wa} == (r_len - LP_ONE));
   assign w_len_zero  = (len == '0);
   assign w_len_bad   = (len > LP_DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_wa      <= '0;
         r_ln      <= '0;
         r_len     <= '0;
         r_shift   <= '0;
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_we      <= '0;
         r_waddr   <= '0;
         r_raddr   <= '0;
         r_din     <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_we   <= '0;
         case (r_state)
            S_IDLE: begin
               if (start_load || start_dump) begin
                  r_wa  <= '0;
                  r_ln  <= '0;
                  r_len <= len;
                  if (w_len_zero) begin
                     r_done <= 1'b1;
                  end else if (w_len_bad) begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else if (start_load) begin
                     r_state   <= S_LOAD;
                     r_s_ready <= 1'b1;
                     r_busy    <= 1'b1;
                  end else begin
                     r_state <= S_DREQ;
                     r_raddr <= '0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  r_we    <= 4'b0001 << r_ln;
                  r_waddr <= r_wa;
                  r_din   <= {4{s_data}};
                  r_ln    <= r_ln + 2'd1;
                  if (r_ln == 2'd3) begin
                     if (w_last_word) begin
                        r_state   <= S_IDLE;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                     end else begin
                        r_wa <= r_wa + LP_WA1;
                     end
                  end
               end
            end
            S_DREQ: begin
               r_state <= S_DWAIT;
            end
            S_DWAIT: begin
               r_shift   <= mem_q;
               r_m_valid <= 1'b1;
               r_state   <= S_EMIT;
            end
            S_EMIT: begin
               if (m_ready) begin
                  r_shift <= {8'h00, r_shift[31:8]};
                  r_ln    <= r_ln + 2'd1;
                  if (r_ln == 2'd3) begin
                     r_m_valid <= 1'b0;
                     if (w_last_word) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_wa    <= r_wa + LP_WA1;
                        r_raddr <= r_wa + LP_WA1;
                        r_state <= S_DREQ;
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready   = r_s_ready;
   assign m_valid   = r_m_valid;
   assign m_data    = r_shift[7:0];
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_we    = r_we;
   assign mem_waddr = r_waddr;
   assign mem_din   = r_din;
   assign mem_raddr = r_raddr;

endmodule

// File: tb/tb_mem_stream_port.sv
// Bench for mem_stream_port: a behavioural RAM plus a byte-addressed reference image,
// driven by directed and randomized load/dump sequences.
module tb_mem_stream_port;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_load;
   logic          start_dump;
   logic [AW:0]   len;
   logic          s_valid;
   logic          s_ready;
   logic [7:0]    s_data;
   logic          m_valid;
   logic          m_ready;
   logic [7:0]    m_data;
   logic          busy;
   logic          done;
   logic          err;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_din;
   logic [AW-1:0] mem_raddr;
   logic [31:0]   mem_q;

   mem_stream_port #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start_load(start_load), .start_dump(start_dump),
      .len(len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
      .done(done), .err(err), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_din(mem_din), .mem_raddr(mem_raddr), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   logic [31:0] ram     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        ram_init_done = 1'b0;
   logic [7:0]  src     [4*DEPTH];
   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
   endfunction

   // Block RAM: byte-lane writes, registered read (data valid one cycle after address).
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int unsigned i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
         ram_init_done <= 1'b1;
      end else begin
         for (int unsigned b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_waddr][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_q <= ram[mem_raddr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_s_ready"},   64'(s_ready),   64'(0));
      chk({tag, "_m_valid"},   64'(m_valid),   64'(0));
      chk({tag, "_m_data"},    64'(m_data),    64'(0));
      chk({tag, "_busy"},      64'(busy),      64'(0));
      chk({tag, "_done"},      64'(done),      64'(0));
      chk({tag, "_err"},       64'(err),       64'(0));
      chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
      chk({tag, "_mem_waddr"}, 64'(mem_waddr), 64'(0));
      chk({tag, "_mem_din"},   64'(mem_din),   64'(0));
      chk({tag, "_mem_raddr"}, 64'(mem_raddr), 64'(0));
   endtask

   task automatic cmp_ram(input string tag, input int unsigned n);
      int unsigned bad = 0;
      for (int unsigned i = 0; i < n; i++) if (ram[i] !== ref_mem[i]) bad++;
      chk(tag, 64'(bad), 64'(0));
   endtask

   task automatic fill_random(input int unsigned nbytes);
      for (int unsigned i = 0; i < nbytes; i++) src[i] = 8'($urandom);
   endtask

   task automatic fill_directed();
      for (int unsigned i = 0; i < 8; i++) src[i] = 8'((i + 1) * 17);
   endtask

   // Feeds 4*L bytes from src; abort_after > 0 asserts reset once that many bytes were accepted.
   task automatic do_load(input int unsigned L, input bit rand_valid, input bit collide,
                          input bit chain_dump, input int unsigned abort_after);
      int unsigned idx = 0;
      int unsigned prev_i = 0;
      int unsigned guard = 0;
      bit          prev_hs = 1'b0;
      bit          fin = 1'b0;
      logic [7:0]  prev_b = '0;
      start_load = 1'b1;
      start_dump = collide;
      len        = (AW+1)'(L);
      @(negedge clk);
      start_load = 1'b0;
      start_dump = 1'b0;
      len        = (AW+1)'($urandom);
      chk("load_busy", 64'(busy), 64'(1));
      while (!fin) begin
         if (prev_hs) begin
            chk("load_we",    64'(mem_we),    64'(4'b0001 << (prev_i % 4)));
            chk("load_waddr", 64'(mem_waddr), 64'(prev_i / 4));
            chk("load_din",   64'(mem_din),   64'({4{prev_b}}));
         end else begin
            chk("load_we_quiet", 64'(mem_we), 64'(0));
         end
         chk("load_m_valid", 64'(m_valid), 64'(0));
         if (abort_after != 0 && idx == abort_after) begin
            reset   = 1'b1;
            s_valid = 1'b1;
            s_data  = src[idx];
            @(negedge clk);
            check_idle_zero("abort");
            reset   = 1'b0;
            s_valid = 1'b0;
            fin     = 1'b1;
         end else if (idx == 4*L) begin
            chk("load_done",    64'(done),    64'(1));
            chk("load_err",     64'(err),     64'(0));
            chk("load_end_busy", 64'(busy),   64'(0));
            chk("load_end_rdy", 64'(s_ready), 64'(0));
            s_valid    = 1'b0;
            start_dump = chain_dump;
            if (chain_dump) len = (AW+1)'(L);
            fin = 1'b1;
         end else begin
            chk("load_done_early", 64'(done),    64'(0));
            chk("load_s_ready",    64'(s_ready), 64'(1));
            s_valid    = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data     = s_valid ? src[idx] : 8'($urandom);
            start_dump = (idx == 1);
            prev_hs    = s_valid;
            prev_b     = s_data;
            prev_i     = idx;
            if (s_valid) begin
               ref_mem[idx/4][8*(idx%4) +: 8] = src[idx];
               idx++;
            end
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
               chk("load_timeout", 64'(guard), 64'(0));
               fin = 1'b1;
            end
         end
      end
      if (!chain_dump && abort_after == 0) begin
         @(negedge clk);
         chk("load_done_clear", 64'(done),    64'(0));
         chk("load_idle_busy",  64'(busy),    64'(0));
         chk("load_idle_mv",    64'(m_valid), 64'(0));
         chk("load_idle_we",    64'(mem_we),  64'(0));
      end
   endtask

   // mode 0: m_ready always 1, 1: toggle 1,0,..., 2: random.
   task automatic do_dump(input int unsigned L, input bit issue_start, input int unsigned mode);
      int unsigned idx = 0;
      int unsigned cyc = 0;
      int unsigned guard = 0;
      bit          tog = 1'b1;
      bit          stalled = 1'b0;
      bit          fin = 1'b0;
      logic [7:0]  expb;
      if (issue_start) begin
         start_dump = 1'b1;
         len        = (AW+1)'(L);
      end
      @(negedge clk);
      start_dump = 1'b0;
      start_load = 1'b0;
      len        = (AW+1)'($urandom);
      m_ready    = 1'($urandom_range(0, 1));
      chk("dump_busy",       64'(busy),      64'(1));
      chk("dump_raddr0",     64'(mem_raddr), 64'(0));
      chk("dump_dreq_valid", 64'(m_valid),   64'(0));
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      chk("dump_dwait_valid", 64'(m_valid), 64'(0));
      @(negedge clk);
      chk("dump_first_valid", 64'(m_valid), 64'(1));
      cyc = 3;
      while (!fin) begin
         if (idx == 4*L) begin
            chk("dump_done",     64'(done),    64'(1));
            chk("dump_err",      64'(err),     64'(0));
            chk("dump_end_busy", 64'(busy),    64'(0));
            chk("dump_end_mv",   64'(m_valid), 64'(0));
            if (mode == 0) chk("dump_cycles", 64'(cyc), 64'(6*L + 1));
            start_load = 1'b0;
            m_ready    = 1'b0;
            fin        = 1'b1;
         end else begin
            chk("dump_done_early", 64'(done),    64'(0));
            chk("dump_we",         64'(mem_we),  64'(0));
            chk("dump_s_ready",    64'(s_ready), 64'(0));
            if (stalled) chk("dump_hold_valid", 64'(m_valid), 64'(1));
            if (m_valid) begin
               expb = ref_mem[idx/4][8*(idx%4) +: 8];
               chk("dump_data",  64'(m_data),    64'(expb));
               chk("dump_raddr", 64'(mem_raddr), 64'(idx / 4));
            end
            case (mode)
               0:       m_ready = 1'b1;
               1:       begin m_ready = tog; tog = !tog; end
               default: m_ready = 1'($urandom_range(0, 1));
            endcase
            stalled = m_valid && !m_ready;
            if (m_valid && m_ready) idx++;
            start_load = (idx == 1);
            @(negedge clk);
            cyc++;
            guard++;
            if (guard > 20000) begin
               chk("dump_timeout", 64'(guard), 64'(0));
               fin = 1'b1;
            end
         end
      end
      @(negedge clk);
      chk("dump_done_clear", 64'(done), 64'(0));
      chk("dump_idle_busy",  64'(busy), 64'(0));
   endtask

   task automatic do_bad(input bit is_load, input int unsigned L, input bit exp_err);
      start_load = is_load;
      start_dump = !is_load;
      len        = (AW+1)'(L);
      @(negedge clk);
      start_load = 1'b0;
      start_dump = 1'b0;
      chk("len_done",    64'(done),    64'(1));
      chk("len_err",     64'(err),     64'(exp_err));
      chk("len_busy",    64'(busy),    64'(0));
      chk("len_we",      64'(mem_we),  64'(0));
      chk("len_m_valid", 64'(m_valid), 64'(0));
      chk("len_s_ready", 64'(s_ready), 64'(0));
      @(negedge clk);
      chk("len_done_clear", 64'(done),   64'(0));
      chk("len_err_clear",  64'(err),    64'(0));
      chk("len_idle_busy",  64'(busy),   64'(0));
      chk("len_idle_we",    64'(mem_we), 64'(0));
   endtask

   initial begin
      logic [31:0] old1;
      int unsigned L;
      reset      = 1'b1;
      start_load = 1'b0;
      start_dump = 1'b0;
      len        = '0;
      s_valid    = 1'b0;
      s_data     = '0;
      m_ready    = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_busy", 64'(busy), 64'(0));

      fill_directed();
      do_load(2, 1'b0, 1'b0, 1'b0, 0);
      chk("ram0_direct", 64'(ram[0]), 64'(32'h4433_2211));
      chk("ram1_direct", 64'(ram[1]), 64'(32'h8877_6655));
      do_dump(2, 1'b1, 1);

      fill_random(4);
      do_load(1, 1'b1, 1'b0, 1'b1, 0);
      do_dump(1, 1'b0, 0);
      fill_random(12);
      do_load(3, 1'b1, 1'b0, 1'b1, 0);
      do_dump(3, 1'b0, 2);
      cmp_ram("ram_chain", DEPTH);

      do_bad(1'b1, 0, 1'b0);
      do_bad(1'b0, 0, 1'b0);
      do_bad(1'b1, 1025, 1'b1);
      do_bad(1'b0, 1025, 1'b1);
      do_bad(1'b0, 2047, 1'b1);

      fill_random(4);
      do_load(1, 1'b1, 1'b1, 1'b0, 0);
      cmp_ram("ram_collide", DEPTH);

      fill_random(4*DEPTH);
      do_load(DEPTH, 1'b1, 1'b0, 1'b0, 0);
      cmp_ram("ram_full", DEPTH);
      do_dump(5, 1'b1, 2);

      for (int unsigned r = 0; r < 4; r++) begin
         L = $urandom_range(1, 8);
         fill_random(4*L);
         do_load(L, 1'b1, 1'b0, 1'b0, 0);
         cmp_ram("ram_rand", DEPTH);
         do_dump(L, 1'b1, $urandom_range(0, 2));
      end

      old1 = ref_mem[1];
      fill_directed();
      do_load(2, 1'b0, 1'b0, 1'b0, 6);
      chk("abort_ram0", 64'(ram[0]), 64'(32'h4433_2211));
      chk("abort_ram1", 64'(ram[1]), 64'({old1[31:16], 16'h6655}));
      cmp_ram("abort_ram", DEPTH);
      do_dump(2, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
